// File: rtl/rv32_mem_arbiter.sv
// Shares one fixed-latency synchronous memory between instruction fetch and load/store.
// Data wins by default; a saturating starvation count eventually forces a fetch through.
module rv32_mem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            rv32_clk,
  input  logic            rv32_rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);
  localparam int unsigned Last      = MEM_LAT - 1;

  logic [3:0]         starve_q, starve_d;
  // Tag pipeline: valid marks a read awaiting data, own is 1 for the data side.
  logic [MEM_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;
  logic [MEM_LAT-1:0] shift_valid, shift_own;
  logic               new_valid, new_own;

  always_comb begin
    if_gnt = if_req & ~if_flush & (~d_req | (starve_q == StarveMax));
    d_gnt  = d_req & ~if_gnt;
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    if (if_gnt) begin
      mem_addr = if_addr;
      mem_be   = 4'hF;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_we ? d_be : 4'hF;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    new_valid = if_gnt | (d_gnt & ~d_we);
    new_own   = d_gnt;
  end

  if (MEM_LAT > 1) begin : g_shift
    assign shift_valid = {tag_valid_q[MEM_LAT-2:0], new_valid};
    assign shift_own   = {tag_own_q[MEM_LAT-2:0], new_own};
  end else begin : g_single
    assign shift_valid = new_valid;
    assign shift_own   = new_own;
  end

  // A flush kills every fetch-owned tag, including ones that just shifted into place.
  always_comb begin
    tag_own_d   = shift_own;
    tag_valid_d = if_flush ? (shift_valid & shift_own) : shift_valid;
  end

  always_ff @(posedge rv32_clk or negedge rv32_rst_n) begin
    if (!rv32_rst_n) begin
      starve_q    <= 4'd0;
      tag_valid_q <= '0;
      tag_own_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      tag_valid_q <= tag_valid_d;
      tag_own_q   <= tag_own_d;
    end
  end

  always_comb begin
    if_rvalid = tag_valid_q[Last] & ~tag_own_q[Last];
    d_rvalid  = tag_valid_q[Last] & tag_own_q[Last];
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Randomised scoreboard bench for rv32_mem_arbiter with a byte-masked memory macro model.
module tb_rv32_mem_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MEM_LAT    = 3;
  localparam int unsigned STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_req, if_flush, if_gnt, if_rvalid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            d_req, d_we, d_gnt, d_rvalid;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]      d_be, mem_be;
  logic            mem_en, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

  rv32_mem_arbiter #(
    .XLEN      (XLEN),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .rv32_clk  (clk),
    .rv32_rst_n(rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory macro: reads return MEM_LAT cycles after the issuing cycle; idle slots carry garbage.
  logic [31:0] env_mem [128];
  logic [31:0] ref_mem [128];
  logic [31:0] rd_pipe [MEM_LAT];
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && !mem_we) rd_pipe[0] <= env_mem[mem_addr[8:2]];
    else rd_pipe[0] <= $urandom;
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) env_mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    int unsigned due;
    bit          is_d;
    logic [31:0] data;
  } resp_t;
  resp_t       exp_q[$];
  int unsigned starve = 0;

  // Monitor: compares the response ports against the scoreboard every cycle.
  always @(negedge clk) begin
    resp_t       r;
    logic        e_if, e_d;
    logic [31:0] e_data;
    e_if = 1'b0;
    e_d = 1'b0;
    e_data = '0;
    if (!rst_n) begin
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        r = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL lost_resp: got nothing, expected %h due cycle %0d", r.data, r.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        e_if = !r.is_d;
        e_d = r.is_d;
        e_data = r.data;
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if));
      chk("d_rvalid", 32'(d_rvalid), 32'(e_d));
      chk("if_rdata", if_rdata, e_if ? e_data : 32'd0);
      chk("d_rdata", d_rdata, e_d ? e_data : 32'd0);
    end
  end

  // One cycle of stimulus plus the reference model's view of who should win it.
  task automatic step(input bit ireq, input logic [31:0] iaddr, input bit flush,
                      input bit dreq, input bit dwe, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input logic [3:0] dbe,
                      output bit got_if, output bit got_d);
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    @(posedge clk);
    #1;
    if_req = ireq; if_addr = iaddr; if_flush = flush;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata; d_be = dbe;
    @(negedge clk);
    #2;
    got_if = ireq && !flush && (!dreq || starve == STARVE_MAX);
    got_d  = dreq && !got_if;
    e_addr = got_if ? iaddr : (got_d ? daddr : 32'd0);
    e_be   = got_if ? 4'hF : (got_d ? (dwe ? dbe : 4'hF) : 4'h0);
    chk("if_gnt", 32'(if_gnt), 32'(got_if));
    chk("d_gnt", 32'(d_gnt), 32'(got_d));
    chk("mem_en", 32'(mem_en), 32'(got_if || got_d));
    chk("mem_we", 32'(mem_we), 32'(got_d && dwe));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_be", 32'(mem_be), 32'(e_be));
    if (got_d && dwe) chk("mem_wdata", mem_wdata, dwdata);
    if (!got_if && !got_d) chk("idle_wdata", mem_wdata, 32'd0);

    if (ireq && !got_if) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
    else starve = 0;
    if (flush) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) if (!exp_q[i].is_d) exp_q.delete(i);
    end
    if (got_if) exp_q.push_back('{cyc + MEM_LAT, 1'b0, ref_mem[iaddr[8:2]]});
    if (got_d && !dwe) exp_q.push_back('{cyc + MEM_LAT, 1'b1, ref_mem[daddr[8:2]]});
    if (got_d && dwe) begin
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[daddr[8:2]][8*b +: 8] = dwdata[8*b +: 8];
    end
  endtask

  task automatic idle(input int n);
    bit gi, gd;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
  endtask

  initial begin
    bit          gi, gd, pf, pd, fl, pwe;
    logic [31:0] fa, da, dw, v;
    logic [3:0]  pbe;
    if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    for (int i = 0; i < 128; i++) begin
      v = (i == 32) ? 32'd0 : ((i == 64) ? 32'hDEADBEEF : $urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end

    repeat (2) @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    #2 rst_n = 1'b1;
    idle(3);

    // Read-back of a preloaded word.
    step(0, 0, 0, 1, 0, 32'h100, 0, 4'h0, gi, gd);
    chk("rb_d_gnt", 32'(d_gnt), 32'd1);
    chk("rb_mem_addr", mem_addr, 32'h100);
    idle(MEM_LAT + 1);

    // Contention: fetch gets through once every STARVE_MAX+1 cycles.
    for (int k = 0; k < 15; k++) begin
      step(1, 32'h10, 0, 1, 0, 32'h20, 0, 4'h0, gi, gd);
      chk("pattern_if_gnt", 32'(if_gnt), 32'((k % 5) == 4));
    end
    idle(MEM_LAT + 1);

    // Interleaved fetch/data reads.
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 1, 0, 32'h40, 0, 0, gi, gd);
    step(1, 32'h4, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 1, 0, 32'h44, 0, 0, gi, gd);
    idle(MEM_LAT + 1);

    // Partial store then read-back.
    step(0, 0, 0, 1, 1, 32'h80, 32'h1234ABCD, 4'b0011, gi, gd);
    chk("st_mem_be", 32'(mem_be), 32'h3);
    idle(2);
    step(0, 0, 0, 1, 0, 32'h80, 0, 0, gi, gd);
    chk("st_readback_model", ref_mem[32], 32'h0000ABCD);
    idle(MEM_LAT + 1);

    // Flush with three fetches in flight and a load issued alongside.
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, gi, gd);
    step(1, 32'hC, 0, 0, 0, 0, 0, 0, gi, gd);
    step(1, 32'h10, 0, 0, 0, 0, 0, 0, gi, gd);
    step(1, 32'h14, 1, 1, 0, 32'h48, 0, 0, gi, gd);
    chk("flush_if_gnt", 32'(if_gnt), 32'd0);
    idle(MEM_LAT + 2);

    // Reset while two reads are outstanding.
    step(0, 0, 0, 1, 0, 32'h4C, 0, 0, gi, gd);
    step(1, 32'h50, 0, 0, 0, 0, 0, 0, gi, gd);
    idle(1);
    @(posedge clk);
    #1;
    chk("pre_rst_d_rvalid", 32'(d_rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("mid_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    exp_q.delete();
    starve = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(MEM_LAT + 3);

    // Random traffic: requests held until granted, occasional flushes and stores.
    pf = 0; pd = 0; fa = 0; da = 0; dw = 0; pwe = 0; pbe = 0;
    repeat (500) begin
      if (!pf && $urandom_range(0, 3) != 0) begin
        pf = 1;
        fa = 32'($urandom_range(0, 127)) << 2;
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1;
        da = 32'($urandom_range(0, 127)) << 2;
        dw = $urandom;
        pwe = ($urandom_range(0, 2) == 0);
        pbe = 4'($urandom);
      end
      fl = ($urandom_range(0, 15) == 0);
      step(pf, fa, fl, pd, pwe, da, dw, pbe, gi, gd);
      if (gi) pf = 0;
      if (gd) pd = 0;
      if (fl && pf) fa = 32'($urandom_range(0, 127)) << 2;
    end
    idle(MEM_LAT + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
